// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    parameter int USE_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     write,
    output logic [WIDTH-1:0]         data_in,
    input  logic                     full_n,
    input  logic [USE_W-1:0]         use_dw,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [USE_W:0] DEPTH_W = (USE_W+1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]       state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic [USE_W:0]   fill;
    logic             space;
    logic             own_req;
    logic [WIDTH-1:0] own_data;
    logic             accept;
    logic             release_grant;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   next_ptr;

    // The registered write is a word the FIFO has not counted yet.
    assign fill  = {1'b0, use_dw} + {{USE_W{1'b0}}, write};
    assign space = full_n && (fill < DEPTH_W);

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                own_req  = req[k];
                own_data = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept        = (state == ST_OWN) && own_req && space;
    assign release_grant = (state == ST_OWN) &&
                           (!own_req || (accept && (cnt == CW'(BURST-1))));
    assign next_ptr      = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    assign busy          = (state == ST_OWN);

    // Requester with the smallest rotational distance from ptr wins.
    always_comb begin : rr_pick
        int best;
        int off;
        best = NREQ;
        off  = 0;
        pick = '0;
        for (int k = 0; k < NREQ; k++) begin
            off = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + NREQ - int'(ptr));
            if (req[k] && (off < best)) begin
                best = off;
                pick = IDW'(k);
            end
        end
    end

    always_comb begin
        ack = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (rst_n && accept && (gnt_id == IDW'(k))) begin
                ack[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            write   <= 1'b0;
            data_in <= '0;
            gnt_id  <= '0;
        end else begin
            write <= accept;
            if (accept) begin
                data_in <= own_data;
                cnt     <= cnt + CW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state  <= ST_OWN;
                        gnt_id <= pick;
                        cnt    <= '0;
                    end
                end
                default: begin
                    if (release_grant) begin
                        state <= ST_IDLE;
                        ptr   <= next_ptr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter with a FIFO and arbitration model
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int USE_W = 6;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       ack;
    logic                  write;
    logic [WIDTH-1:0]      data_in;
    logic                  full_n = 1'b1;
    logic [USE_W-1:0]      use_dw = '0;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .BURST(BURST), .USE_W(USE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .write(write), .data_in(data_in), .full_n(full_n), .use_dw(use_dw),
        .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO environment
    logic [WIDTH-1:0] fifo_q[$];
    bit               pend_wr;
    bit               pend_rd;
    logic [WIDTH-1:0] pend_data;
    bit               rst_at_edge = 1'b0;
    int               rd_pct = 0;
    bit               rd_once = 1'b0;

    // producers
    bit               has_word[NREQ];
    logic [WIDTH-1:0] word[NREQ];
    int               words_left[NREQ];
    int               prob[NREQ];

    // reference model: current owner (-1 = arbitrating), words taken, rotation start
    int               m_owner = -1;
    int               m_cnt = 0;
    int               m_ptr = 0;
    int               m_gnt = 0;
    bit               m_inflight = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    int               wait_grants[NREQ];

    int ack_log[$];
    int ack_cyc[$];
    int cycle = 0;
    int n_writes = 0;

    task automatic grant(input int k);
        for (int j = 0; j < NREQ; j++) begin
            if (j != k && req[j]) wait_grants[j]++;
        end
        check("fairness", wait_grants[k] <= NREQ-1, 1);
        wait_grants[k] = 0;
        m_owner = k;
        m_gnt   = k;
        m_cnt   = 0;
    endtask

    task automatic step(input bit rst_val);
        logic [NREQ-1:0] exp_ack;
        bit acc;
        bit rel;
        bit found;
        @(negedge clk);
        cycle++;
        if (!rst_at_edge) begin
            fifo_q.delete();
        end else begin
            if (pend_rd) void'(fifo_q.pop_front());
            if (pend_wr) fifo_q.push_back(pend_data);
        end
        check("fifo_level", fifo_q.size() <= DEPTH, 1);
        check("write", write, m_inflight);
        if (write) n_writes++;
        if (m_inflight) begin
            if (exp_q.size() == 0) check("exp_queue", 0, 1);
            else check("data_in", data_in, exp_q.pop_front());
        end
        check("busy", busy, m_owner >= 0);
        check("gnt_id", gnt_id, m_gnt);
        if (!rst_at_edge) check("data_in_rst", data_in, 0);
        pend_wr   = write;
        pend_data = data_in;

        rst_n   = rst_val;
        pend_rd = (fifo_q.size() > 0) && (rd_once || ($urandom_range(99) < rd_pct));
        rd_once = 1'b0;
        use_dw  = USE_W'(fifo_q.size());
        full_n  = fifo_q.size() < DEPTH;
        for (int k = 0; k < NREQ; k++) begin
            if (!has_word[k] && words_left[k] != 0 && $urandom_range(99) < prob[k]) begin
                has_word[k] = 1'b1;
                word[k]     = WIDTH'($urandom);
                if (words_left[k] > 0) words_left[k]--;
            end
            req[k] = has_word[k];
            req_data[k*WIDTH +: WIDTH] = word[k];
        end
        rst_at_edge = rst_val;
        #1;
        exp_ack = '0;
        if (!rst_val) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_gnt = 0; m_inflight = 1'b0;
            exp_q.delete();
            for (int j = 0; j < NREQ; j++) wait_grants[j] = 0;
        end else if (m_owner < 0) begin
            m_inflight = 1'b0;
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[(m_ptr + i) % NREQ]) begin
                    found = 1'b1;
                    grant((m_ptr + i) % NREQ);
                end
            end
        end else begin
            acc = req[m_owner] && full_n && (fifo_q.size() + int'(m_inflight) < DEPTH);
            if (acc) begin
                exp_ack[m_owner] = 1'b1;
                exp_q.push_back(word[m_owner]);
                has_word[m_owner] = 1'b0;
                ack_log.push_back(m_owner);
                ack_cyc.push_back(cycle);
            end
            rel = !req[m_owner] || (acc && m_cnt == BURST-1);
            if (acc) m_cnt++;
            m_inflight = acc;
            if (rel) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        check("ack", ack, exp_ack);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < NREQ; k++) has_word[k] = 1'b0;
        repeat (n) step(1'b0);
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic set_prod(input int k, input int p, input int words);
        prob[k]       = p;
        words_left[k] = words;
    endtask

    task automatic check_groups();
        int grp[$];
        int run;
        int gap_bad;
        run = 1;
        gap_bad = 0;
        for (int i = 1; i < ack_cyc.size(); i++) begin
            if (ack_cyc[i] == ack_cyc[i-1] + 1) begin
                run++;
            end else begin
                grp.push_back(run);
                if (ack_cyc[i] - ack_cyc[i-1] != 2) gap_bad++;
                run = 1;
            end
        end
        if (ack_cyc.size() > 0) grp.push_back(run);
        check("t2_groups", grp.size(), 3);
        if (grp.size() == 3) begin
            check("t2_group0", grp[0], 4);
            check("t2_group1", grp[1], 4);
            check("t2_group2", grp[2], 2);
        end
        check("t2_gaps", gap_bad, 0);
    endtask

    initial begin
        int snap_w;
        // reset values
        do_reset(2);

        // reset mid-burst with a write in flight, then restart with 2 and 3 requesting
        for (int k = 0; k < NREQ; k++) set_prod(k, 100, -1);
        rd_pct = 100;
        repeat (8) step(1'b1);
        check("t1_owner_before", gnt_id, 1);
        set_prod(0, 0, 0);
        set_prod(1, 0, 0);
        do_reset(2);
        step(1'b1);
        check("t1_busy", busy, 0);
        check("t1_write", write, 0);
        repeat (11) step(1'b1);
        check("t1_first", (ack_log.size() > 0) ? ack_log[0] : -1, 2);

        // single producer, 10 words, no reads
        for (int k = 0; k < NREQ; k++) set_prod(k, 0, 0);
        set_prod(2, 100, 10);
        rd_pct = 0;
        do_reset(2);
        repeat (20) step(1'b1);
        check("t2_words", ack_log.size(), 10);
        check("t2_fifo", fifo_q.size(), 10);
        check("t2_use_dw", use_dw, 10);
        check_groups();

        // all continuous with reads: 20 words in 25 cycles, order 0,1,2,3,0
        for (int k = 0; k < NREQ; k++) set_prod(k, 100, -1);
        rd_pct = 100;
        do_reset(2);
        repeat (25) step(1'b1);
        check("t3_count", ack_log.size(), 20);
        for (int i = 0; i < ack_log.size(); i++) check("t3_order", ack_log[i], (i / BURST) % NREQ);

        // fill to DEPTH, stall, then a single read admits exactly one more word
        rd_pct = 0;
        do_reset(2);
        repeat (50) step(1'b1);
        check("t4_count", ack_log.size(), DEPTH);
        check("t4_fifo", fifo_q.size(), DEPTH);
        snap_w = n_writes;
        repeat (10) step(1'b1);
        check("t4_stall_acks", ack_log.size(), DEPTH);
        check("t4_stall_writes", n_writes - snap_w, 0);
        rd_once = 1'b1;
        repeat (10) step(1'b1);
        check("t4_after_read", ack_log.size(), DEPTH + 1);
        check("t4_fifo_after", fifo_q.size(), DEPTH);

        // owner 1 drops after 2 words; next grant to 2, then variant with 3
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < NREQ; k++) set_prod(k, 0, 0);
            set_prod(1, 100, 2);
            set_prod(2 + t, 100, -1);
            rd_pct = 100;
            do_reset(2);
            repeat (10) step(1'b1);
            check("t5_len", ack_log.size() >= 3, 1);
            if (ack_log.size() >= 3) begin
                check("t5_ack0", ack_log[0], 1);
                check("t5_ack1", ack_log[1], 1);
                check("t5_next", ack_log[2], 2 + t);
            end
        end

        // randomized traffic with plentiful and scarce FIFO space
        for (int k = 0; k < NREQ; k++) set_prod(k, $urandom_range(20, 100), -1);
        rd_pct = 70;
        do_reset(2);
        repeat (1200) step(1'b1);
        do_reset(1);
        for (int k = 0; k < NREQ; k++) set_prod(k, $urandom_range(20, 100), -1);
        rd_pct = 15;
        repeat (1500) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
